wb_minterm_blitter: RTL and testbench

Parametrised successor of the OCS blitter: a 32-bit Wishbone rectangle blitter with three sources (A, B, C) and a destination (D).
- Each destination word is an 8-entry minterm function of A, B and C.
- Adds a configurable address width, wider size counters, descending mode and a DMA pause input.
- Sits beside the other OCS DMA masters; a CPU-side Wishbone slave programs it.

---
 rtl/wb_blitter_pkg.sv | 40 ++++
 rtl/blt_minterm.sv | 18 +
 rtl/wb_minterm_blitter.sv | 211 +++++++++++++++++++++
 tb/tb_wb_minterm_blitter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_blitter_pkg.sv
// Shared definitions for the Wishbone minterm blitter: slave register
// indices, CON bit positions, FSM state encoding and the byte-lane merge
// used by slave writes.
package wb_blitter_pkg;

  localparam logic [3:0] R_CON    = 4'd0;
  localparam logic [3:0] R_SIZE   = 4'd1;
  localparam logic [3:0] R_APTR   = 4'd2;
  localparam logic [3:0] R_BPTR   = 4'd3;
  localparam logic [3:0] R_CPTR   = 4'd4;
  localparam logic [3:0] R_DPTR   = 4'd5;
  localparam logic [3:0] R_AMOD   = 4'd6;
  localparam logic [3:0] R_BMOD   = 4'd7;
  localparam logic [3:0] R_CMOD   = 4'd8;
  localparam logic [3:0] R_DMOD   = 4'd9;
  localparam logic [3:0] R_STATUS = 4'd10;
  localparam logic [3:0] R_ADAT   = 4'd11;
  localparam logic [3:0] R_BDAT   = 4'd12;
  localparam logic [3:0] R_CDAT   = 4'd13;

  // CON[11:8] = USED,USEC,USEB,USEA ; CON[12] = DESC
  localparam int CON_USE  = 8;
  localparam int CON_DESC = 12;

  // Access states are consecutive so "next state" is a simple increment.
  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_RD_C, S_WR_D, S_ADV, S_DONE
  } state_t;

  function automatic logic [31:0] sel_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/blt_minterm.sv
// Combinational minterm lookup: each output bit selects LF[{A,B,C}] for
// its bit position.
// Ports: lf (8-entry truth table), a/b/c (source words), d (result).
module blt_minterm #(
  parameter int W = 32
) (
  input  logic [7:0]   lf,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] d
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign d[i] = lf[{a[i], b[i], c[i]}];
  end

endmodule

// File: rtl/wb_minterm_blitter.sv
// Wishbone rectangle blitter: reads A/B/C, writes D = minterm(LF, A, B, C)
// over a width x height rectangle with per-row modulo and optional
// descending addressing.
// Ports: CLK_I/reset_n; Wishbone master (CYC_O..ACK_I); Wishbone slave
// register port (CYC_I..ACK_O); dma_en pause; irq/zero/busy status.
module wb_minterm_blitter
  import wb_blitter_pkg::*;
#(
  parameter int ADR_W  = 30,
  parameter int SIZE_W = 12
) (
  input  logic              CLK_I,
  input  logic              reset_n,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  output logic [ADR_W-1:0]  ADR_O,
  output logic [3:0]        SEL_O,
  output logic [31:0]       master_DAT_O,
  input  logic [31:0]       master_DAT_I,
  input  logic              ACK_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [3:0]        ADR_I,
  input  logic [3:0]        SEL_I,
  input  logic [31:0]       slave_DAT_I,
  output logic [31:0]       slave_DAT_O,
  output logic              ACK_O,
  input  logic              dma_en,
  output logic              blitter_irq,
  output logic              blitter_zero,
  output logic              blitter_busy
);

  localparam logic [ADR_W-1:0]  ONE     = ADR_W'(1);
  localparam logic [SIZE_W-1:0] CNT_ONE = SIZE_W'(1);

  state_t                  state;
  logic [12:0]             con;
  logic [SIZE_W-1:0]       width, height, wcnt, hcnt;
  logic [3:0][ADR_W-1:0]   ptr, adv_ptr;   // A,B,C,D
  logic [3:0][15:0]        mods;
  logic [2:0][31:0]        dat;            // A,B,C held data
  logic                    busy, zero, irq, stb, we, ack;
  logic [ADR_W-1:0]        adr;
  logic [31:0]             wdat, slv_rdat, rd_val, merged, d;
  logic [3:0]              use_bits;
  logic [1:0]              acc;
  logic                    use_acc, is_wr, leave, eor, slv_req, wr_fire;

  assign CYC_O        = stb;
  assign STB_O        = stb;
  assign WE_O         = we;
  assign ADR_O        = adr;
  assign SEL_O        = 4'hF;
  assign master_DAT_O = wdat;
  assign slave_DAT_O  = slv_rdat;
  assign ACK_O        = ack;
  assign blitter_irq  = irq;
  assign blitter_zero = zero;
  assign blitter_busy = busy;

  blt_minterm #(.W(32)) u_lf (
    .lf(con[7:0]), .a(dat[0]), .b(dat[1]), .c(dat[2]), .d(d)
  );

  function automatic logic [ADR_W-1:0] sext(input logic [15:0] m);
    return ADR_W'($signed(m));
  endfunction

  assign use_bits = con[CON_USE +: 4];
  assign is_wr    = (state == S_WR_D);
  assign use_acc  = use_bits[acc];
  // An unused access state falls straight through; a used one leaves on ACK.
  assign leave    = !use_acc || (stb && ACK_I);
  assign eor      = (wcnt == CNT_ONE);
  assign slv_req  = CYC_I && STB_I && !ack;
  assign wr_fire  = slv_req && WE_I;
  assign merged   = sel_merge(rd_val, slave_DAT_I, SEL_I);

  // Pointer index of the access state (A=0 .. D=3).
  always_comb begin
    case (state)
      S_RD_B:  acc = 2'd1;
      S_RD_C:  acc = 2'd2;
      S_WR_D:  acc = 2'd3;
      default: acc = 2'd0;
    endcase
  end

  // Next pointer value in ADV; modulo folds in only at end of row.
  always_comb begin
    adv_ptr = ptr;
    for (int i = 0; i < 4; i++)
      adv_ptr[i] = con[CON_DESC] ? ptr[i] - ONE - (eor ? sext(mods[i]) : '0)
                                 : ptr[i] + ONE + (eor ? sext(mods[i]) : '0);
  end

  // Live register view; also the "old" value for byte-masked writes.
  always_comb begin
    rd_val = '0;
    case (ADR_I)
      R_CON:  rd_val[12:0] = con;
      R_SIZE: begin
        rd_val[SIZE_W-1:0]   = width;
        rd_val[16 +: SIZE_W] = height;
      end
      R_APTR, R_BPTR, R_CPTR, R_DPTR: rd_val[ADR_W-1:0] = ptr[ADR_I[1:0] - 2'd2];
      R_AMOD, R_BMOD, R_CMOD, R_DMOD: rd_val[15:0] = mods[ADR_I[1:0] - 2'd2];
      R_STATUS: rd_val[1:0] = {zero, busy};
      R_ADAT, R_BDAT, R_CDAT: rd_val = dat[ADR_I[1:0] - 2'd3];
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I or negedge reset_n) begin
    if (!reset_n) begin
      ack      <= 1'b0;
      slv_rdat <= '0;
    end else begin
      ack <= slv_req;
      if (slv_req && !WE_I) slv_rdat <= rd_val;
    end
  end

  always_ff @(posedge CLK_I or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      con    <= '0;
      width  <= '0;
      height <= '0;
      wcnt   <= '0;
      hcnt   <= '0;
      ptr    <= '0;
      mods   <= '0;
      dat    <= '0;
      busy   <= 1'b0;
      zero   <= 1'b1;
      irq    <= 1'b0;
      stb    <= 1'b0;
      we     <= 1'b0;
      adr    <= '0;
      wdat   <= '0;
    end else begin
      irq <= 1'b0;

      if (wr_fire && !busy) begin
        case (ADR_I)
          R_CON: con <= merged[12:0];
          R_SIZE: if (state == S_IDLE) begin
            width  <= merged[SIZE_W-1:0];
            height <= merged[16 +: SIZE_W];
            wcnt   <= merged[SIZE_W-1:0];
            hcnt   <= merged[16 +: SIZE_W];
            zero   <= 1'b1;
            if (merged[SIZE_W-1:0] == '0 || merged[16 +: SIZE_W] == '0) begin
              state <= S_DONE;
              irq   <= 1'b1;
            end else begin
              state <= S_RD_A;
              busy  <= 1'b1;
            end
          end
          R_APTR, R_BPTR, R_CPTR, R_DPTR: ptr[ADR_I[1:0] - 2'd2]  <= merged[ADR_W-1:0];
          R_AMOD, R_BMOD, R_CMOD, R_DMOD: mods[ADR_I[1:0] - 2'd2] <= merged[15:0];
          R_ADAT, R_BDAT, R_CDAT:         dat[ADR_I[1:0] - 2'd3]  <= merged;
          default: ;
        endcase
      end

      case (state)
        S_RD_A, S_RD_B, S_RD_C, S_WR_D: begin
          if (leave) begin
            stb   <= 1'b0;
            we    <= 1'b0;
            state <= state_t'(state + 3'd1);
            if (is_wr && d != '0) zero <= 1'b0;
            if (!is_wr && use_acc) dat[acc] <= master_DAT_I;
          end else if (!stb && dma_en) begin
            stb  <= 1'b1;
            we   <= is_wr;
            adr  <= ptr[acc];
            wdat <= d;
          end
        end
        S_ADV: begin
          for (int i = 0; i < 4; i++)
            if (use_bits[i]) ptr[i] <= adv_ptr[i];
          if (eor) begin
            wcnt <= width;
            hcnt <= hcnt - CNT_ONE;
            if (hcnt == CNT_ONE) begin
              state <= S_DONE;
              busy  <= 1'b0;
              irq   <= 1'b1;
            end else begin
              state <= S_RD_A;
            end
          end else begin
            wcnt  <= wcnt - CNT_ONE;
            state <= S_RD_A;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_minterm_blitter.sv
// Self-checking bench for wb_minterm_blitter: Wishbone memory responder,
// rectangle-level reference model with an expected-access queue checked at
// every master acknowledge, plus literal expectations from hand calculation.
module tb_wb_minterm_blitter;

  localparam int ADR_W  = 30;
  localparam int SIZE_W = 12;
  localparam longint MASK = (64'd1 << ADR_W) - 1;

  localparam logic [3:0] A_CON = 4'd0, A_SIZE = 4'd1, A_PTR0 = 4'd2,
                         A_MOD0 = 4'd6, A_STAT = 4'd10, A_DAT0 = 4'd11;

  logic              CLK_I = 1'b0;
  logic              reset_n;
  logic              CYC_O, STB_O, WE_O;
  logic [ADR_W-1:0]  ADR_O;
  logic [3:0]        SEL_O;
  logic [31:0]       master_DAT_O, master_DAT_I;
  logic              ACK_I;
  logic              CYC_I, STB_I, WE_I;
  logic [3:0]        ADR_I, SEL_I;
  logic [31:0]       slave_DAT_I, slave_DAT_O;
  logic              ACK_O, dma_en, blitter_irq, blitter_zero, blitter_busy;

  wb_minterm_blitter #(.ADR_W(ADR_W), .SIZE_W(SIZE_W)) dut (
    .CLK_I(CLK_I), .reset_n(reset_n),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .SEL_O(SEL_O),
    .master_DAT_O(master_DAT_O), .master_DAT_I(master_DAT_I), .ACK_I(ACK_I),
    .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I), .SEL_I(SEL_I),
    .slave_DAT_I(slave_DAT_I), .slave_DAT_O(slave_DAT_O), .ACK_O(ACK_O),
    .dma_en(dma_en), .blitter_irq(blitter_irq), .blitter_zero(blitter_zero),
    .blitter_busy(blitter_busy)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {bit we; longint adr; logic [31:0] dat;} acc_t;

  int          checks = 0, errors = 0;
  logic [31:0] mem [0:1023];
  acc_t        exp_q[$];
  longint      rd_log[$], wr_log[$];
  int          ack_delay = 0, irq_cnt = 0, stb_cyc = 0, rd_cnt = 0, wr_cnt = 0;

  // Software view of programmed registers
  logic [12:0] sh_con;
  logic [31:0] sh_ptr [4];
  logic [15:0] sh_mod [4];
  logic [31:0] sh_dat [3];
  longint      exp_ptr [4];
  bit          exp_zero;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Memory-side responder and per-access compare against the model queue.
  initial begin
    int wc;
    logic [ADR_W-1:0] hold;
    acc_t e;
    wc = 0; hold = '0; ACK_I = 1'b0; master_DAT_I = '0;
    forever begin
      @(negedge CLK_I);
      if (!reset_n || ACK_I) begin
        ACK_I = 1'b0;
        wc = 0;
      end else if (STB_O) begin
        if (wc > 0) chk("adr_hold", ADR_O, hold);
        else hold = ADR_O;
        if (wc < ack_delay) wc++;
        else begin
          ACK_I = 1'b1;
          wc = 0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_access: adr %0h we %0b", ADR_O, WE_O);
          end else begin
            e = exp_q.pop_front();
            chk("acc_we", WE_O, e.we);
            chk("acc_adr", ADR_O, ADR_W'(e.adr));
            if (e.we) chk("acc_dat", master_DAT_O, e.dat);
          end
          if (WE_O) begin
            mem[ADR_O[9:0]] = master_DAT_O; wr_log.push_back(ADR_O); wr_cnt++;
          end else begin
            master_DAT_I = mem[ADR_O[9:0]]; rd_log.push_back(ADR_O); rd_cnt++;
          end
        end
      end else wc = 0;
    end
  end

  initial forever begin
    @(negedge CLK_I);
    if (blitter_irq) begin
      irq_cnt++;
      chk("busy_low_at_irq", blitter_busy, 1'b0);
    end
    if (STB_O) stb_cyc++;
  end

  // Sum-of-products form of the minterm function.
  function automatic logic [31:0] lf_eval(input logic [7:0] lf, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
    logic [31:0] r;
    r = '0;
    for (int m = 0; m < 8; m++)
      if (lf[m]) r |= (m[2] ? a : ~a) & (m[1] ? b : ~b) & (m[0] ? c : ~c);
    return r;
  endfunction

  task automatic model_blit(input int w, input int h);
    longint p [4];
    logic [31:0] v [3];
    logic [31:0] dv;
    longint dir;
    for (int s = 0; s < 4; s++) p[s] = sh_ptr[s];
    for (int s = 0; s < 3; s++) v[s] = sh_dat[s];
    dir = sh_con[12] ? -1 : 1;
    exp_zero = 1'b1;
    for (int r = 0; r < h && w > 0; r++)
      for (int c = 0; c < w; c++) begin
        for (int s = 0; s < 3; s++)
          if (sh_con[8+s]) begin
            exp_q.push_back('{1'b0, p[s], 32'h0});
            v[s] = mem[p[s] & 1023];
          end
        dv = lf_eval(sh_con[7:0], v[0], v[1], v[2]);
        if (dv != 0) exp_zero = 1'b0;
        if (sh_con[11]) exp_q.push_back('{1'b1, p[3], dv});
        for (int s = 0; s < 4; s++)
          if (sh_con[8+s])
            p[s] = (p[s] + dir * (1 + ((c == w - 1) ? longint'($signed(sh_mod[s])) : 0))) & MASK;
      end
    for (int s = 0; s < 4; s++) exp_ptr[s] = p[s];
    for (int s = 0; s < 3; s++) sh_dat[s] = v[s];
  endtask

  task automatic wb_write_sel(input logic [3:0] a, input logic [31:0] v, input logic [3:0] sel);
    bit got;
    got = 0;
    @(negedge CLK_I);
    CYC_I = 1; STB_I = 1; WE_I = 1; ADR_I = a; slave_DAT_I = v; SEL_I = sel;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge CLK_I);
      if (ACK_O) got = 1;
    end
    CYC_I = 0; STB_I = 0; WE_I = 0;
    if (!got) fail_now("slave_write_ack");
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] v);
    wb_write_sel(a, v, 4'hF);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] v);
    bit got;
    got = 0; v = '0;
    @(negedge CLK_I);
    CYC_I = 1; STB_I = 1; WE_I = 0; ADR_I = a; SEL_I = 4'hF;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge CLK_I);
      if (ACK_O) begin got = 1; v = slave_DAT_O; end
    end
    CYC_I = 0; STB_I = 0;
    if (!got) fail_now("slave_read_ack");
  endtask

  task automatic set_con(input logic [12:0] v);
    wb_write(A_CON, 32'(v)); sh_con = v;
  endtask
  task automatic set_ptr(input int s, input logic [31:0] v);
    wb_write(4'(A_PTR0 + s), v); sh_ptr[s] = v;
  endtask
  task automatic set_mod(input int s, input logic [15:0] v);
    wb_write(4'(A_MOD0 + s), 32'(v)); sh_mod[s] = v;
  endtask
  task automatic set_dat(input int s, input logic [31:0] v);
    wb_write(4'(A_DAT0 + s), v); sh_dat[s] = v;
  endtask

  task automatic begin_blit(input int w, input int h);
    model_blit(w, h);
    wb_write(A_SIZE, (32'(h) << 16) | 32'(w));
  endtask

  task automatic end_blit(input string tag, input int st);
    bit seen;
    logic [31:0] rv;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge CLK_I);
      if (irq_cnt > st) seen = 1;
    end
    if (!seen) fail_now({tag, "_irq"});
    repeat (3) @(negedge CLK_I);
    chk({tag, "_irq_pulses"}, irq_cnt - st, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_zero"}, blitter_zero, exp_zero);
    for (int s = 0; s < 4; s++) begin
      wb_read(4'(A_PTR0 + s), rv);
      chk({tag, "_ptr"}, rv, exp_ptr[s]);
      sh_ptr[s] = 32'(exp_ptr[s]);
    end
  endtask

  task automatic run_blit(input int w, input int h, input string tag);
    int st;
    st = irq_cnt;
    begin_blit(w, h);
    end_blit(tag, st);
  endtask

  task automatic clear_shadow();
    sh_con = '0;
    for (int s = 0; s < 4; s++) begin sh_ptr[s] = '0; sh_mod[s] = '0; end
    for (int s = 0; s < 3; s++) sh_dat[s] = '0;
  endtask

  initial begin
    logic [31:0] rv;
    int st, t0, t1;
    bit seen;
    reset_n = 0; CYC_I = 0; STB_I = 0; WE_I = 0; ADR_I = '0; SEL_I = '0;
    slave_DAT_I = '0; dma_en = 1;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    clear_shadow();
    repeat (3) @(negedge CLK_I);
    chk("rst_stb", STB_O, 0);
    chk("rst_busy", blitter_busy, 0);
    chk("rst_zero", blitter_zero, 1);
    chk("rst_irq", blitter_irq, 0);
    chk("rst_ack", ACK_O, 0);
    reset_n = 1;
    wb_read(A_STAT, rv);
    chk("rst_status", rv, 32'h2);
    chk("sel_o", SEL_O, 4'hF);

    // Byte-enable on slave write: only the low CON byte lands
    wb_write(A_CON, 32'h0);
    wb_write_sel(A_CON, 32'hFFFF_FFFF, 4'b0001);
    wb_read(A_CON, rv);
    chk("con_sel_byte", rv, 32'hFF);

    // Copy A->D
    mem[100] = 1; mem[101] = 2; mem[102] = 3; mem[103] = 4;
    set_con(13'h9F0);
    for (int s = 0; s < 4; s++) set_mod(s, 16'h0);
    set_ptr(0, 100); set_ptr(3, 200);
    run_blit(2, 2, "copy");
    for (int i = 0; i < 4; i++) chk("copy_mem", mem[200+i], 32'(i + 1));
    wb_read(A_PTR0, rv);
    chk("copy_aptr_104", rv, 104);
    chk("copy_zero_lit", blitter_zero, 0);

    // Fill with LF=FF, no sources
    st = rd_cnt; t0 = wr_cnt;
    set_con(13'h8FF);
    set_ptr(3, 300);
    run_blit(3, 1, "fill");
    chk("fill_no_reads", rd_cnt - st, 0);
    chk("fill_writes", wr_cnt - t0, 3);
    for (int i = 0; i < 3; i++) chk("fill_mem", mem[300+i], 32'hFFFF_FFFF);

    // Descending with modulo
    mem[13] = 32'hA; mem[12] = 32'hB; mem[9] = 32'hC; mem[8] = 32'hD;
    rd_log.delete(); wr_log.delete();
    set_con(13'h19F0);
    set_ptr(0, 13); set_ptr(3, 23); set_mod(0, 16'd2); set_mod(3, 16'd2);
    run_blit(2, 2, "desc");
    chk("desc_nrd", rd_log.size(), 4);
    chk("desc_nwr", wr_log.size(), 4);
    if (rd_log.size() == 4 && wr_log.size() == 4) begin
      chk("desc_rd0", rd_log[0], 13); chk("desc_rd1", rd_log[1], 12);
      chk("desc_rd2", rd_log[2], 9);  chk("desc_rd3", rd_log[3], 8);
      chk("desc_wr0", wr_log[0], 23); chk("desc_wr1", wr_log[1], 22);
      chk("desc_wr2", wr_log[2], 19); chk("desc_wr3", wr_log[3], 18);
    end
    chk("desc_mem18", mem[18], 32'hD);
    wb_read(A_PTR0, rv);
    chk("desc_aptr_5", rv, 5);

    // AND with C held at all-ones through C_DAT
    mem[400] = 32'hF0F0_F0F0; mem[410] = 32'h0F0F_0F0F;
    set_mod(0, 0); set_mod(1, 0); set_mod(3, 0);
    set_con(13'hB80);
    set_dat(2, 32'hFFFF_FFFF);
    set_ptr(0, 400); set_ptr(1, 410); set_ptr(3, 420);
    run_blit(1, 1, "and0");
    chk("and0_zero_lit", blitter_zero, 1);
    chk("and0_mem", mem[420], 32'h0);
    mem[410] = 32'hFFFF_FFFF;
    set_ptr(0, 400); set_ptr(1, 410); set_ptr(3, 421);
    run_blit(1, 1, "and1");
    chk("and1_zero_lit", blitter_zero, 0);
    chk("and1_mem", mem[421], 32'hF0F0_F0F0);

    // DMA pause, busy-write ignore, slow ACK
    mem[500] = 32'h1234_5678;
    dma_en = 0;
    set_con(13'h9F0);
    set_ptr(0, 500); set_ptr(3, 510);
    st = irq_cnt;
    begin_blit(1, 1);
    t0 = stb_cyc;
    repeat (20) @(negedge CLK_I);
    chk("dma_no_stb", stb_cyc - t0, 0);
    chk("dma_busy", blitter_busy, 1);
    wb_write(A_PTR0, 32'h77);
    wb_read(A_PTR0, rv);
    chk("busy_write_ignored", rv, 500);
    ack_delay = 5;
    dma_en = 1;
    end_blit("dma", st);
    chk("dma_mem", mem[510], 32'h1234_5678);
    ack_delay = 0;

    // Reset while the D write waits for ACK
    ack_delay = 1000;
    set_con(13'h8FF);
    set_ptr(3, 600);
    begin_blit(1, 1);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK_I);
      if (STB_O && WE_O) seen = 1;
    end
    if (!seen) fail_now("rst_wait_wr");
    reset_n = 0;
    #1;
    chk("midrst_stb", STB_O, 0);
    chk("midrst_busy", blitter_busy, 0);
    chk("midrst_zero", blitter_zero, 1);
    exp_q.delete();
    ack_delay = 0;
    clear_shadow();
    repeat (2) @(negedge CLK_I);
    reset_n = 1;
    wb_read(A_STAT, rv);
    chk("midrst_status", rv, 32'h2);
    mem[700] = 32'h5A5A_0001;
    set_con(13'h9F0);
    set_ptr(0, 700); set_ptr(3, 710);
    run_blit(1, 1, "post_rst");
    chk("post_rst_mem", mem[710], 32'h5A5A_0001);

    // Zero width: irq, no bus cycles, zero back to 1
    t1 = stb_cyc;
    run_blit(0, 5, "zero_w");
    chk("zero_w_no_bus", stb_cyc - t1, 0);
    chk("zero_w_zero_lit", blitter_zero, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
